// File: rtl/mix_sequence_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mix_sequence_ctrl
// Brief  : PRIME/LOAD/DWELL/DISPENSE valve and pump sequencer for the mixer
//          network. Define CYCLE_COUNT_EN to add the run_count output.
// Rev    : 1.0  initial release
// ============================================================================
module mix_sequence_ctrl #(
    parameter int CNT_W    = 16,
    parameter int PUMP_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] t_prime,
    input  logic [CNT_W-1:0] t_load,
    input  logic [CNT_W-1:0] t_dwell,
    input  logic [CNT_W-1:0] t_disp,
    output logic             valve_soln1,
    output logic             valve_soln2,
    output logic             valve_soln3,
    output logic             valve_out,
    output logic [2:0]       pump_ph,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [2:0]       state
`ifdef CYCLE_COUNT_EN
    ,
    output logic [7:0]       run_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRIME    = 3'd1,
        S_LOAD     = 3'd2,
        S_DWELL    = 3'd3,
        S_DISPENSE = 3'd4,
        S_GAP      = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam int c_div_w = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;

    state_t             r_state;
    state_t             r_gap_next;
    logic [CNT_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_tl;
    logic [CNT_W-1:0]   r_tw;
    logic [CNT_W-1:0]   r_td;
    logic [2:0]         r_pidx;
    logic [c_div_w-1:0] r_pdiv;

    state_t             w_state_nxt;
    state_t             w_gap_nxt;
    logic [CNT_W-1:0]   w_timer_nxt;
    logic               w_tick;
    logic               w_launch;
    logic               w_pump_run;
    logic               w_pump_on_nxt;
    logic [2:0]         w_pidx_nxt;
    logic [c_div_w-1:0] w_pdiv_nxt;

    // A zero duration still occupies one cycle, so the timer counts max(t,1)-1 down to 0.
    function automatic logic [CNT_W-1:0] dur_m1(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - CNT_W'(1);
    endfunction

    function automatic logic [2:0] pump_pat(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b100;
            3'd1:    return 3'b110;
            3'd2:    return 3'b010;
            3'd3:    return 3'b011;
            3'd4:    return 3'b001;
            3'd5:    return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic pump_state(input state_t s);
        return (s == S_PRIME) || (s == S_LOAD) || (s == S_DISPENSE);
    endfunction

    assign w_tick   = (r_timer == '0);
    assign w_launch = (r_state == S_IDLE) && start && !abort;

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_next;
        w_timer_nxt = w_tick ? r_timer : r_timer - CNT_W'(1);
        if ((r_state != S_IDLE) && abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        w_state_nxt = S_PRIME;
                        w_timer_nxt = dur_m1(t_prime);
                    end
                end
                S_PRIME: begin
                    if (w_tick) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_tick) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (w_tick) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = S_DISPENSE;
                    end
                end
                S_GAP: begin
                    w_state_nxt = r_gap_next;
                    case (r_gap_next)
                        S_LOAD:  w_timer_nxt = dur_m1(r_tl);
                        S_DWELL: w_timer_nxt = dur_m1(r_tw);
                        default: w_timer_nxt = dur_m1(r_td);
                    endcase
                end
                S_DISPENSE: begin
                    if (w_tick) w_state_nxt = S_DONE;
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Pump position only moves while a pumping stage is active and is carried across stages.
    assign w_pump_run    = pump_state(r_state);
    assign w_pump_on_nxt = pump_state(w_state_nxt);

    always_comb begin
        w_pidx_nxt = r_pidx;
        w_pdiv_nxt = r_pdiv;
        if (w_pump_run) begin
            if (r_pdiv == c_div_w'(PUMP_DIV - 1)) begin
                w_pdiv_nxt = '0;
                w_pidx_nxt = (r_pidx == 3'd5) ? 3'd0 : r_pidx + 3'd1;
            end else begin
                w_pdiv_nxt = r_pdiv + c_div_w'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gap_next  <= S_IDLE;
            r_timer     <= '0;
            r_tl        <= '0;
            r_tw        <= '0;
            r_td        <= '0;
            r_pidx      <= 3'd0;
            r_pdiv      <= '0;
            valve_soln1 <= 1'b0;
            valve_soln2 <= 1'b0;
            valve_soln3 <= 1'b0;
            valve_out   <= 1'b0;
            pump_ph     <= 3'b000;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gap_next <= w_gap_nxt;
            r_timer    <= w_timer_nxt;
            r_pidx     <= w_pidx_nxt;
            r_pdiv     <= w_pdiv_nxt;
            if (w_launch) begin
                r_tl <= t_load;
                r_tw <= t_dwell;
                r_td <= t_disp;
            end
            // Outputs are decoded from the next state so they line up with the state register.
            valve_soln1 <= (w_state_nxt == S_LOAD);
            valve_soln2 <= (w_state_nxt == S_LOAD);
            valve_soln3 <= (w_state_nxt == S_PRIME);
            valve_out   <= (w_state_nxt == S_DISPENSE);
            pump_ph     <= w_pump_on_nxt ? pump_pat(w_pidx_nxt) : 3'b000;
            busy        <= (w_state_nxt != S_IDLE);
            done        <= (w_state_nxt == S_DONE);
            aborted     <= (r_state != S_IDLE) && abort;
        end
    end

    assign state = r_state;

`ifdef CYCLE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_count <= 8'd0;
        end else if ((w_state_nxt == S_DONE) && (run_count != 8'hFF)) begin
            run_count <= run_count + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire
